clk_div_multi: RTL and testbench
================================

# clk_div_multi

Multi-channel, parametrised integer clock divider. Successor to the single-channel divider in the clock-generation area. Each channel divides `clk_ref` by its own runtime ratio, switches ratio glitch-free only at period boundaries, and emits a one-cycle rising-edge tick. Channels with ratio 0/1 or disabled bypass to `clk_ref`.

## Interface
- `WIDTH`, 8, ratio width per channel (max ratio 2^WIDTH-1)
- `CHANNELS`, 4, number of independent divider channels
- `clk_ref`  in  1  reference clock, the only clock
- `rst`  in  1  asynchronous, active-low reset
- `i_clk_en`  in  CHANNELS  per-channel enable, level
- `div_ratio`  in  CHANNELS*WIDTH  requested ratio, channel k at [k*WIDTH +: WIDTH]
- `o_div_clk`  out  CHANNELS  divided clock per channel (bypass = `clk_ref`)
- `o_tick`  out  CHANNELS  one-`clk_ref`-cycle pulse coincident with each `o_div_clk` rising edge
- `o_ratio_ack`  out  CHANNELS  one-cycle pulse when a changed ratio is taken into the active register

## Operation
- Per channel: active ratio `r_act` (WIDTH), period counter `cnt` (WIDTH), registered `div_clk`, `tick`, `ack`.
- `run = i_clk_en && (r_act >= 2)`. Output mux: `o_div_clk = run ? div_clk : clk_ref`.
- Running, each edge: `div_clk <= (cnt < (r_act>>1))`; `tick <= (cnt == 0)`; `cnt <= (cnt == r_act-1) ? 0 : cnt+1`.
- Duty: even R high R/2, low R/2. Odd R high (R-1)/2, low (R+1)/2 (see Configuration).
- Ratio update: `r_act <= div_ratio` at the wrap edge (`cnt == r_act-1`) when running, every edge when not running. `ack` pulses when the loaded value differs from the old `r_act`.
- Wrap and ratio change on the same edge: new ratio loaded, `cnt` goes 0, the next period runs entirely at the new ratio. There is no truncated or stretched period.
- New ratio 0/1 while running: taken at the wrap, then the channel drops to bypass.
- `i_clk_en` deasserted mid-period: takes effect on the next edge. `cnt` goes 0, `div_clk` goes 0, `tick` goes 0, and the output is muxed to `clk_ref` immediately. The current period is abandoned.
- Channels are fully independent. No cross-channel phase alignment.

## Timing
- Reset (`rst` = 0): `cnt` = 0, `div_clk` = 0, `tick` = 0, `ack` = 0, `r_act` = 0. Therefore `o_div_clk` = `clk_ref` (bypass), `o_tick` = 0, `o_ratio_ack` = 0.
- Ratio write while idle to first divided output: `r_act` loads on edge 1. `run` is true after edge 1. `div_clk` and `tick` rise on edge 2.
- With `r_act` already ≥ 2, enable rising is sampled on edge n. `o_div_clk` rises and `o_tick` pulses on edge n+1.
- `tick` is high for exactly one `clk_ref` cycle per divided period.
- `ack` is asserted in the cycle after the load edge, for one cycle.

## Configuration
- `CLK_DIV_ODD_DUTY50_EN` defined:
  - Each channel adds a negedge-`clk_ref` flop (async reset to 0) sampling `div_clk`.
  - For odd `r_act`, `o_div_clk = div_clk | neg_ff`, extending the high phase by half a `clk_ref` cycle to give exactly 50% duty.
  - Even ratios and bypass are unchanged.
- Undefined: no negedge logic. Odd ratios use the (R-1)/2 high, (R+1)/2 low duty above.

## Structure
- Package `clk_div_pkg`:
  - `CLK_DIV_MIN_RATIO` = 2
  - default `WIDTH`/`CHANNELS`
  - helper function for the half-ratio (`r>>1`)
- Sub-module `clk_div_chan`: one channel (counter, ratio shadow, output mux, optional negedge flop). The top only generates `CHANNELS` instances and slices the buses.

## Test plan
- Reset, then ch0 ratio 4 with enable: after the first rise, `o_div_clk` is 2 high / 2 low. `o_tick` pulses every 4 cycles. `o_ratio_ack` pulses once.
- Ratio 5 with the macro off: 2 high / 3 low. With the macro on: 2.5/2.5 measured at both `clk_ref` edges.
- Ratio changed 4→6 mid-period at `cnt` = 1: the current 4-cycle period completes. `ack` pulses after the wrap. The next period is 3 high / 3 low, with no runt pulse.
- Ratio 0 or 1, or enable low: `o_div_clk` tracks `clk_ref`. `o_tick` stays 0. Enable drops mid-high: `o_div_clk` is `clk_ref` the next cycle.
- 4 channels at ratios 2, 3, 7, 255 concurrently: each period and tick rate is correct and independent. Async reset asserted mid-run returns all outputs to reset values immediately.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int CLK_DIV_MIN_RATIO = 2;
    localparam int CLK_DIV_WIDTH     = 8;
    localparam int CLK_DIV_CHANNELS  = 4;

    // Length of the high phase of one divided period, in clk_ref cycles.
    function automatic logic [31:0] clk_div_half(input logic [31:0] r);
        return r >> 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Channel bundle of the multi-channel divider: per-channel enable/ratio in,
// divided clock, tick and ratio acknowledge out.
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int WIDTH    = CLK_DIV_WIDTH,
    parameter int CHANNELS = CLK_DIV_CHANNELS
);

    // No backpressure: enable and ratio are levels sampled on every clk_ref edge;
    // o_ratio_ack is a one-cycle pulse after a differing ratio lands in the active register.
    logic [CHANNELS-1:0]       i_clk_en;
    logic [CHANNELS*WIDTH-1:0] div_ratio;
    logic [CHANNELS-1:0]       o_div_clk;
    logic [CHANNELS-1:0]       o_tick;
    logic [CHANNELS-1:0]       o_ratio_ack;

    modport master (
        output i_clk_en, div_ratio,
        input  o_div_clk, o_tick, o_ratio_ack
    );

    modport slave (
        input  i_clk_en, div_ratio,
        output o_div_clk, o_tick, o_ratio_ack
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, ratio shadow, bypass mux.
// CLK_DIV_ODD_DUTY50_EN adds a negedge flop that stretches odd-ratio high phases to 50% duty.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int WIDTH = CLK_DIV_WIDTH
) (
    input  logic             clk_ref,
    input  logic             rst,
    input  logic             i_clk_en,
    input  logic [WIDTH-1:0] i_ratio,
    output logic             o_div_clk,
    output logic             o_tick,
    output logic             o_ratio_ack
);

    logic [WIDTH-1:0] r_act;
    logic [WIDTH-1:0] r_cnt;
    logic             r_div_clk;
    logic             r_tick;
    logic             r_ack;
    logic             r_en;

    logic             w_run;
    logic             w_count;
    logic             w_wrap;
    logic [WIDTH-1:0] w_half;
    logic             w_div_out;

    assign w_run   = i_clk_en && (r_act >= WIDTH'(CLK_DIV_MIN_RATIO));
    // Counting waits one edge after enable is first seen, so the first rise lands one edge later.
    assign w_count = w_run && r_en;
    assign w_wrap  = (r_cnt == (r_act - WIDTH'(1)));
    assign w_half  = WIDTH'(clk_div_half(32'(r_act)));

    always_ff @(posedge clk_ref or negedge rst) begin
        if (!rst) begin
            r_act     <= '0;
            r_cnt     <= '0;
            r_div_clk <= 1'b0;
            r_tick    <= 1'b0;
            r_ack     <= 1'b0;
            r_en      <= 1'b0;
        end else begin
            r_en  <= i_clk_en;
            r_ack <= 1'b0;
            if (w_count) begin
                r_div_clk <= (r_cnt < w_half);
                r_tick    <= (r_cnt == '0);
                if (w_wrap) begin
                    r_cnt <= '0;
                    r_act <= i_ratio;
                    r_ack <= (i_ratio != r_act);
                end else begin
                    r_cnt <= r_cnt + WIDTH'(1);
                end
            end else begin
                r_cnt     <= '0;
                r_div_clk <= 1'b0;
                r_tick    <= 1'b0;
                if (!w_run) begin
                    r_act <= i_ratio;
                    r_ack <= (i_ratio != r_act);
                end
            end
        end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic r_neg;

    always_ff @(negedge clk_ref or negedge rst) begin
        if (!rst) begin
            r_neg <= 1'b0;
        end else begin
            r_neg <= r_div_clk;
        end
    end

    // Holding the high phase across the falling-edge half cycle balances odd ratios.
    assign w_div_out = r_act[0] ? (r_div_clk | r_neg) : r_div_clk;
`else
    assign w_div_out = r_div_clk;
`endif

    assign o_div_clk   = w_run ? w_div_out : clk_ref;
    assign o_tick      = r_tick;
    assign o_ratio_ack = r_ack;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider: CHANNELS independent clk_div_chan instances.
// Optional odd-ratio 50% duty via CLK_DIV_ODD_DUTY50_EN (handled inside each channel).
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int WIDTH    = CLK_DIV_WIDTH,
    parameter int CHANNELS = CLK_DIV_CHANNELS
) (
    input  logic           clk_ref,
    input  logic           rst,
    clk_div_multi_if.slave bus
);

    logic [CHANNELS-1:0] w_div_clk;
    logic [CHANNELS-1:0] w_tick;
    logic [CHANNELS-1:0] w_ack;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        clk_div_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk_ref     (clk_ref),
            .rst         (rst),
            .i_clk_en    (bus.i_clk_en[k]),
            .i_ratio     (bus.div_ratio[k*WIDTH +: WIDTH]),
            .o_div_clk   (w_div_clk[k]),
            .o_tick      (w_tick[k]),
            .o_ratio_ack (w_ack[k])
        );
    end

    assign bus.o_div_clk   = w_div_clk;
    assign bus.o_tick      = w_tick;
    assign bus.o_ratio_ack = w_ack;

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: per-cycle expected waveforms are planned
// from ratio/phase, queued on stimulus, and compared at both clk_ref edges.
module tb_clk_div_multi;

    localparam int W    = 8;
    localparam int CH   = 4;
    localparam int MAXC = 600;
`ifdef CLK_DIV_ODD_DUTY50_EN
    localparam bit DUTY50 = 1'b1;
`else
    localparam bit DUTY50 = 1'b0;
`endif

    logic clk_ref;
    logic rst;

    clk_div_multi_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

    clk_div_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk_ref (clk_ref),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    int checks   = 0;
    int failures = 0;

    // Entry layout: {ack, tick, div at negedge, div at posedge}, 4 bits each.
    logic [15:0] exp_q[$];

    logic [3:0] p_pos  [0:MAXC-1];
    logic [3:0] p_neg  [0:MAXC-1];
    logic [3:0] p_tick [0:MAXC-1];
    logic [3:0] p_ack  [0:MAXC-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic en, input logic [W-1:0] ratio);
        bus.i_clk_en[ch]          = en;
        bus.div_ratio[ch*W +: W]  = ratio;
    endtask

    // Default expectation per cycle: every channel in bypass, no tick, no ack.
    task automatic plan_clear(input int n);
        for (int c = 0; c < n; c++) begin
            p_pos[c]  = 4'hF;
            p_neg[c]  = 4'h0;
            p_tick[c] = 4'h0;
            p_ack[c]  = 4'h0;
        end
    endtask

    task automatic plan_low(input int ch, input int c);
        p_pos[c][ch] = 1'b0;
        p_neg[c][ch] = 1'b0;
    endtask

    task automatic plan_ack(input int ch, input int c);
        p_ack[c][ch] = 1'b1;
    endtask

    // Divided waveform: high R/2 cycles from the period start, tick on the first cycle.
    task automatic plan_run(input int ch, input int start, input int r, input int ph, input int n);
        int p;
        int h;
        bit hi;
        for (int i = 0; i < n; i++) begin
            p  = (ph + i) % r;
            h  = r / 2;
            hi = (p < h);
            p_pos[start+i][ch]  = hi | (DUTY50 && (r % 2 == 1) && (p == h));
            p_neg[start+i][ch]  = hi;
            p_tick[start+i][ch] = (p == 0);
        end
    endtask

    task automatic commit(input int n);
        for (int c = 0; c < n; c++)
            exp_q.push_back({p_ack[c], p_tick[c], p_neg[c], p_pos[c]});
    endtask

    task automatic run_cycles(input int n);
        logic [15:0] e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_ref);
            #1;
            if (exp_q.size() == 0) begin
                check("queue_underrun", 32'(0), 32'(1));
                return;
            end
            e = exp_q.pop_front();
            check("div_pos", 32'(bus.o_div_clk), 32'(e[3:0]));
            check("tick", 32'(bus.o_tick), 32'(e[11:8]));
            check("ack", 32'(bus.o_ratio_ack), 32'(e[15:12]));
            @(negedge clk_ref);
            #1;
            check("div_neg", 32'(bus.o_div_clk), 32'(e[7:4]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b0;
        bus.i_clk_en  = '0;
        bus.div_ratio = '0;

        // Reset state: everything bypassed, no pulses.
        plan_clear(3);
        commit(3);
        run_cycles(3);
        rst = 1'b1;

        // Ratio 4 on ch0 from idle.
        set_ch(0, 1'b1, 8'd4);
        plan_clear(14);
        plan_low(0, 0);
        plan_ack(0, 0);
        plan_run(0, 1, 4, 0, 13);
        commit(14);
        run_cycles(14);

        // 4 -> 6 requested at cnt 1: finish the 4-period, ack at wrap, then 3/3.
        set_ch(0, 1'b1, 8'd6);
        plan_clear(15);
        plan_run(0, 0, 4, 1, 3);
        plan_ack(0, 2);
        plan_run(0, 3, 6, 0, 12);
        commit(15);
        run_cycles(15);

        // Ratio 1 while running: taken at the wrap, then bypass.
        set_ch(0, 1'b1, 8'd1);
        plan_clear(10);
        plan_run(0, 0, 6, 0, 5);
        plan_ack(0, 5);
        commit(10);
        run_cycles(10);

        // Ratio 0 while idle loads immediately (differs from 1).
        set_ch(0, 1'b1, 8'd0);
        plan_clear(4);
        plan_ack(0, 0);
        commit(4);
        run_cycles(4);

        // Ratio 4 again, then drop enable during the high phase.
        set_ch(0, 1'b1, 8'd4);
        plan_clear(2);
        plan_low(0, 0);
        plan_ack(0, 0);
        plan_run(0, 1, 4, 0, 1);
        commit(2);
        run_cycles(2);
        set_ch(0, 1'b0, 8'd4);
        plan_clear(4);
        commit(4);
        run_cycles(4);

        // Re-enable with r_act already 4: rise one edge after enable is sampled.
        set_ch(0, 1'b1, 8'd4);
        plan_clear(9);
        plan_low(0, 0);
        plan_run(0, 1, 4, 0, 8);
        commit(9);
        run_cycles(9);
        set_ch(0, 1'b0, 8'd0);
        plan_clear(3);
        plan_ack(0, 0);
        commit(3);
        run_cycles(3);

        // Odd ratio 5.
        set_ch(0, 1'b1, 8'd5);
        plan_clear(16);
        plan_low(0, 0);
        plan_ack(0, 0);
        plan_run(0, 1, 5, 0, 15);
        commit(16);
        run_cycles(16);
        set_ch(0, 1'b0, 8'd0);
        plan_clear(3);
        plan_ack(0, 0);
        commit(3);
        run_cycles(3);

        // Four channels concurrently at 2, 3, 7, 255.
        set_ch(0, 1'b1, 8'd2);
        set_ch(1, 1'b1, 8'd3);
        set_ch(2, 1'b1, 8'd7);
        set_ch(3, 1'b1, 8'd255);
        plan_clear(530);
        plan_low(0, 0); plan_ack(0, 0); plan_run(0, 1, 2, 0, 529);
        plan_low(1, 0); plan_ack(1, 0); plan_run(1, 1, 3, 0, 529);
        plan_low(2, 0); plan_ack(2, 0); plan_run(2, 1, 7, 0, 529);
        plan_low(3, 0); plan_ack(3, 0); plan_run(3, 1, 255, 0, 529);
        commit(530);
        run_cycles(530);

        // Asynchronous reset mid-run: outputs return to bypass without a clock edge.
        @(posedge clk_ref);
        #2;
        rst = 1'b0;
        #1;
        check("rst_div_high", 32'(bus.o_div_clk), 32'hF);
        check("rst_tick", 32'(bus.o_tick), 32'h0);
        check("rst_ack", 32'(bus.o_ratio_ack), 32'h0);
        @(negedge clk_ref);
        #1;
        check("rst_div_low", 32'(bus.o_div_clk), 32'h0);
        bus.i_clk_en  = '0;
        bus.div_ratio = '0;
        rst           = 1'b1;
        plan_clear(3);
        commit(3);
        run_cycles(3);

        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
